// File: rtl/cache_mem_arbiter.sv
// Shares the pipelined memory port between I- and D-cache: write-through stores
// pass straight through in IDLE, misses get an 8-word read burst steered back.
module cache_mem_arbiter #(
    parameter int BURST_LEN = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_miss,
    input  logic [15:0] i_miss_addr,
    input  logic        d_miss,
    input  logic [15:0] d_miss_addr,
    input  logic        d_wr_req,
    input  logic [15:0] d_wr_addr,
    input  logic [15:0] d_wr_data,
    output logic        d_wr_ack,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_data_valid,
    output logic        i_fill_we,
    output logic [2:0]  i_fill_word,
    output logic [15:0] i_fill_data,
    output logic        i_fill_done,
    output logic        d_fill_we,
    output logic [2:0]  d_fill_word,
    output logic [15:0] d_fill_data,
    output logic        d_fill_done
);
    typedef enum logic [1:0] {IDLE = 2'd0, FILL_I = 2'd1, FILL_D = 2'd2} arbState;

    arbState      state, stateNxt;
    logic [15:4]  base, baseNxt;
    logic [3:0]   issueCnt, issueNxt;
    logic [3:0]   retCnt, retNxt;
    logic         lastGrant, lastGrantNxt;
    logic         grantD;
    logic         issuing;
    logic         lastRet;
    logic         unusedBits;

    // Round-robin tie break: D wins unless D was the previous grant.
    assign grantD     = d_miss && (!i_miss || !lastGrant);
    assign issuing    = issueCnt < 4'(BURST_LEN);
    assign lastRet    = mem_data_valid && (retCnt[2:0] == 3'(BURST_LEN - 1));
    assign unusedBits = ^{i_miss_addr[3:0], d_miss_addr[3:0], retCnt[3]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            base      <= '0;
            issueCnt  <= '0;
            retCnt    <= '0;
            lastGrant <= 1'b0;
        end else begin
            state     <= stateNxt;
            base      <= baseNxt;
            issueCnt  <= issueNxt;
            retCnt    <= retNxt;
            lastGrant <= lastGrantNxt;
        end
    end

    always_comb begin
        stateNxt     = state;
        baseNxt      = base;
        issueNxt     = issueCnt;
        retNxt       = retCnt;
        lastGrantNxt = lastGrant;
        case (state)
            IDLE: begin
                // A pending write holds off arbitration for this cycle.
                if (!d_wr_req && (i_miss || d_miss)) begin
                    stateNxt     = grantD ? FILL_D : FILL_I;
                    lastGrantNxt = grantD;
                    baseNxt      = grantD ? d_miss_addr[15:4] : i_miss_addr[15:4];
                    issueNxt     = '0;
                    retNxt       = '0;
                end
            end
            FILL_I, FILL_D: begin
                if (issuing)        issueNxt = issueCnt + 4'd1;
                if (mem_data_valid) retNxt   = retCnt + 4'd1;
                if (lastRet)        stateNxt = IDLE;
            end
            default: stateNxt = IDLE;
        endcase
    end

    always_comb begin
        d_wr_ack    = 1'b0;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        i_fill_we   = 1'b0;
        i_fill_word = '0;
        i_fill_data = '0;
        i_fill_done = 1'b0;
        d_fill_we   = 1'b0;
        d_fill_word = '0;
        d_fill_data = '0;
        d_fill_done = 1'b0;
        // Reset forces every output low even while d_wr_req is asserted.
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (d_wr_req) begin
                        d_wr_ack  = 1'b1;
                        mem_en    = 1'b1;
                        mem_wr    = 1'b1;
                        mem_addr  = d_wr_addr;
                        mem_wdata = d_wr_data;
                    end
                end
                FILL_I, FILL_D: begin
                    if (issuing) begin
                        mem_en   = 1'b1;
                        mem_addr = {base, issueCnt[2:0], 1'b0};
                    end
                    if (mem_data_valid) begin
                        if (state == FILL_I) begin
                            i_fill_we   = 1'b1;
                            i_fill_word = retCnt[2:0];
                            i_fill_data = mem_rdata;
                            i_fill_done = lastRet;
                        end else begin
                            d_fill_we   = 1'b1;
                            d_fill_word = retCnt[2:0];
                            d_fill_data = mem_rdata;
                            d_fill_done = lastRet;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench: tasks push expected reads/fills/writes, a negedge monitor
// pops and compares, and a queue-based memory returns reads after a latency.
module tb_cache_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss, d_miss, d_wr_req, mem_data_valid;
    logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data, mem_rdata;
    logic        d_wr_ack, mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic        i_fill_we, i_fill_done, d_fill_we, d_fill_done;
    logic [2:0]  i_fill_word, d_fill_word;
    logic [15:0] i_fill_data, d_fill_data;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.BURST_LEN(8)) dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .d_wr_ack(d_wr_ack),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
        .i_fill_we(i_fill_we), .i_fill_word(i_fill_word), .i_fill_data(i_fill_data), .i_fill_done(i_fill_done),
        .d_fill_we(d_fill_we), .d_fill_word(d_fill_word), .d_fill_data(d_fill_data), .d_fill_done(d_fill_done)
    );

    typedef struct { int c; int k; logic [15:0] a; } rdExp;
    typedef struct { int c; int w; logic [15:0] d; } fillExp;
    typedef struct { logic [15:0] a; logic [15:0] d; } wrExp;
    typedef struct { int rdy; logic [15:0] d; } memRet;

    rdExp   addrQ[$];
    fillExp fillQ[$];
    wrExp   wrQ[$];
    memRet  retQ[$];

    int checks = 0, failures = 0;
    int cyc = 0;
    int memLat = 4, gapMax = 0, lastSched = 0;
    int lastWinner = 0;
    int rd0Cyc[2], rd7Cyc[2], doneCyc[2], ackCyc;
    logic [15:0] salt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected traffic for one granted block fill, derived from the miss address.
    task automatic expectFill(input int c, input logic [15:0] a);
        rdExp r;
        fillExp f;
        logic [15:0] b;
        b = a & 16'hFFF0;
        for (int k = 0; k < 8; k++) begin
            r.c = c; r.k = k; r.a = b + 16'(2 * k);
            addrQ.push_back(r);
            f.c = c; f.w = k; f.d = (b + 16'(2 * k)) ^ salt;
            fillQ.push_back(f);
        end
        lastWinner = c;
    endtask

    task automatic missOne(input int c, input logic [15:0] a);
        expectFill(c, a);
        if (c == 0) begin i_miss = 1'b1; i_miss_addr = a; end
        else begin d_miss = 1'b1; d_miss_addr = a; end
    endtask

    task automatic missBoth(input logic [15:0] ia, input logic [15:0] da, output int first);
        first = (lastWinner == 0) ? 1 : 0;
        if (first == 1) begin expectFill(1, da); expectFill(0, ia); end
        else begin expectFill(0, ia); expectFill(1, da); end
        i_miss = 1'b1; i_miss_addr = ia;
        d_miss = 1'b1; d_miss_addr = da;
    endtask

    task automatic waitDone(input int c);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            seen = (c == 0) ? i_fill_done : d_fill_done;
        end
        check("fill_done_seen", seen, 1);
        @(posedge clk); #1;
        if (c == 0) i_miss = 1'b0; else d_miss = 1'b0;
    endtask

    task automatic doWrite(input logic [15:0] a, input logic [15:0] d);
        wrExp w;
        bit seen;
        w.a = a; w.d = d;
        wrQ.push_back(w);
        d_wr_req = 1'b1; d_wr_addr = a; d_wr_data = d;
        seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            seen = d_wr_ack;
        end
        check("wr_ack_seen", seen, 1);
        @(posedge clk); #1;
        d_wr_req = 1'b0;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        fillQ.delete();
        addrQ.delete();
        lastWinner = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Memory: reads return in issue order, no earlier than memLat, spaced by random gaps.
    initial begin : memModel
        memRet m;
        mem_data_valid = 1'b0;
        mem_rdata = 16'd0;
        forever begin
            @(posedge clk); #1;
            if (retQ.size() > 0 && retQ[0].rdy <= cyc) begin
                m = retQ.pop_front();
                mem_data_valid = 1'b1;
                mem_rdata = m.d;
            end else begin
                mem_data_valid = 1'b0;
                mem_rdata = 16'($urandom);
            end
        end
    end

    always @(negedge clk) begin : monitor
        rdExp r;
        fillExp f;
        wrExp w;
        memRet m;
        int gap;
        logic okI, okD, quiet;
        okI = i_fill_we || (i_fill_word == 3'd0 && i_fill_data == 16'd0 && !i_fill_done);
        okD = d_fill_we || (d_fill_word == 3'd0 && d_fill_data == 16'd0 && !d_fill_done);
        quiet = okI && okD && !(i_fill_we && d_fill_we) && (mem_wr || mem_wdata == 16'd0)
                && (d_wr_ack == (mem_en && mem_wr));
        check("quiet_outputs", quiet, 1);
        if (mem_en && !mem_wr) begin
            check("rd_expected", addrQ.size() > 0, 1);
            if (addrQ.size() > 0) begin
                r = addrQ.pop_front();
                check("rd_addr", mem_addr, r.a);
                if (r.k == 0) rd0Cyc[r.c] = cyc;
                if (r.k == 7) rd7Cyc[r.c] = cyc;
            end
            gap = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
            m.rdy = cyc + memLat;
            if (m.rdy < lastSched + 1 + gap) m.rdy = lastSched + 1 + gap;
            lastSched = m.rdy;
            m.d = mem_addr ^ salt;
            retQ.push_back(m);
        end
        if (mem_en && mem_wr) begin
            check("wr_expected", wrQ.size() > 0, 1);
            if (wrQ.size() > 0) begin
                w = wrQ.pop_front();
                check("wr_addr", mem_addr, w.a);
                check("wr_data", mem_wdata, w.d);
            end
            check("wr_ack", d_wr_ack, 1);
            ackCyc = cyc;
        end
        if (i_fill_we || d_fill_we) begin
            check("fill_expected", fillQ.size() > 0, 1);
            if (fillQ.size() > 0) begin
                f = fillQ.pop_front();
                check("fill_cache", d_fill_we ? 1 : 0, f.c);
                check("fill_word", d_fill_we ? d_fill_word : i_fill_word, f.w);
                check("fill_data", d_fill_we ? d_fill_data : i_fill_data, f.d);
                check("fill_done", d_fill_we ? d_fill_done : i_fill_done, f.w == 7);
            end
        end else if (mem_data_valid) begin
            check("valid_without_fill", fillQ.size(), 0);
        end
        if (i_fill_done) doneCyc[0] = cyc;
        if (d_fill_done) doneCyc[1] = cyc;
    end

    initial begin : watchdog
        #500000;
        failures++;
        $display("FAIL watchdog: run did not complete, got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : stimulus
        int t0, first;
        salt = 16'($urandom);
        rst = 1'b1;
        i_miss = 1'b0; d_miss = 1'b0; d_wr_req = 1'b0;
        i_miss_addr = '0; d_miss_addr = '0; d_wr_addr = '0; d_wr_data = '0;
        #1;
        check("reset_ctrl", {mem_en, mem_wr, d_wr_ack, i_fill_we, d_fill_we, i_fill_done, d_fill_done}, 0);
        check("reset_addr", mem_addr, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single I miss, fixed latency 4: reads cycles 1-8, done cycle 12.
        @(posedge clk); #1;
        t0 = cyc;
        missOne(0, 16'h1236);
        waitDone(0);
        check("i_first_read_cycle", rd0Cyc[0] - t0, 1);
        check("i_last_read_cycle", rd7Cyc[0] - t0, 8);
        check("i_done_cycle", doneCyc[0] - t0, 12);

        // Write in IDLE acked same cycle.
        t0 = cyc;
        doWrite(16'h0040, 16'hBEEF);
        check("wr_same_cycle", ackCyc - t0, 0);

        // Simultaneous misses after reset: D, then I right after D's done; repeat gives D first.
        pulseReset();
        @(posedge clk); #1;
        missBoth(16'h2000, 16'h3010, first);
        check("both_first_is_d", first, 1);
        waitDone(first);
        waitDone(1 - first);
        check("i_grant_after_d_done", rd0Cyc[0] - doneCyc[1], 2);
        missBoth(16'h2100, 16'h3100, first);
        check("repeat_first_is_d", first, 1);
        waitDone(first);
        waitDone(1 - first);
        check("repeat_d_before_i", rd0Cyc[1] < rd0Cyc[0], 1);

        // Write and D miss raised during FILL_I: write acked first IDLE cycle, then D.
        fork
            begin
                missOne(0, 16'h4444);
                waitDone(0);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                fork
                    doWrite(16'h0100, 16'h1234);
                    missOne(1, 16'h5550);
                join
                waitDone(1);
            end
        join
        check("wr_ack_after_i_done", ackCyc - doneCyc[0], 1);
        check("d_grant_after_write", rd0Cyc[1] - ackCyc, 2);

        // Reset in cycle 6 of a burst; late returns must be discarded.
        @(posedge clk); #1;
        missOne(0, 16'h6660);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        i_miss = 1'b0;
        fillQ.delete();
        addrQ.delete();
        lastWinner = 0;
        #1;
        check("rst_async_ctrl", {mem_en, mem_wr, d_wr_ack, i_fill_we, d_fill_we, i_fill_done, d_fill_done}, 0);
        check("rst_async_addr", mem_addr, 0);
        check("rst_async_fill", {i_fill_word, i_fill_data}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int n = 0; n < 100 && retQ.size() > 0; n++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check("late_returns_drained", retQ.size(), 0);
        t0 = cyc;
        missOne(0, 16'h7770);
        waitDone(0);
        check("post_reset_done_cycle", doneCyc[0] - t0, 12);

        // Irregular return spacing.
        gapMax = 3;
        missOne(1, 16'h8888);
        waitDone(1);
        check("irregular_fills_consumed", fillQ.size(), 0);
        missOne(0, 16'h9990);
        waitDone(0);
        check("irregular_reads_consumed", addrQ.size(), 0);

        // Random mix of writes and misses with random latency and spacing.
        for (int it = 0; it < 30; it++) begin
            memLat = int'($urandom_range(6, 1));
            gapMax = int'($urandom_range(3, 0));
            case ($urandom_range(3, 0))
                0: doWrite(16'($urandom), 16'($urandom));
                1: begin missOne(0, 16'($urandom)); waitDone(0); end
                2: begin missOne(1, 16'($urandom)); waitDone(1); end
                default: begin
                    missBoth(16'($urandom), 16'($urandom), first);
                    waitDone(first);
                    waitDone(1 - first);
                end
            endcase
            repeat (int'($urandom_range(2, 0))) @(posedge clk);
            #1;
        end
        repeat (4) @(posedge clk);
        #1;
        check("queues_drained", fillQ.size() + addrQ.size() + wrQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
